pipe_wport_arb: RTL and testbench

- Arbitrates the single register-file write port between the pipeline WB stage and a multi-cycle multiply/divide unit.
- WB writes always win. Mul/div results wait in a small in-order FIFO and drain on cycles when WB does not write.
- Sits between the WB stage / mul-div unit and the regfile write inputs (wrn, wdi, wwreg) of the ID stage.
- Also gives the ID stage pending-write hazard flags and a starvation stall request.

---
 rtl/pipe_wport_arb.sv | 122 ++++++++++++
 tb/tb_pipe_wport_arb.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_wport_arb.sv
// Register-file write-port arbiter: WB writes win, mul/div results queue in an
// in-order FIFO and drain on WB-idle cycles, with hazard flags and starvation stall.
module pipe_wport_arb #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wb_wreg,
    input  logic [4:0]               wb_rn,
    input  logic [31:0]              wb_di,
    input  logic                     md_valid,
    input  logic [4:0]               md_rn,
    input  logic [31:0]              md_di,
    output logic                     md_ready,
    input  logic [4:0]               rs,
    input  logic [4:0]               rt,
    output logic                     wwreg,
    output logic [4:0]               wrn,
    output logic [31:0]              wdi,
    output logic                     pend_a,
    output logic                     pend_b,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    logic [4:0]    r_rn [DEPTH];
    logic [31:0]   r_di [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_starve;

    logic w_wb_act;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_pend_a;
    logic w_pend_b;

    assign w_wb_act = wb_wreg & (wb_rn != '0);
    assign w_empty  = (r_cnt == '0);
    assign w_pop    = ~w_wb_act & ~w_empty;
    assign md_ready = ~reset & (r_cnt < CW'(DEPTH));
    // Zero-destination results complete the handshake but are never stored.
    assign w_push   = md_valid & md_ready & (md_rn != '0);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_rn[r_tail] <= md_rn;
            r_di[r_tail] <= md_di;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            r_vld  <= '0;
        end else begin
            if (w_pop) begin
                r_head        <= r_head + AW'(1);
                r_vld[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail        <= r_tail + AW'(1);
                r_vld[r_tail] <= 1'b1;
            end
            if (w_push && !w_pop)
                r_cnt <= r_cnt + CW'(1);
            else if (w_pop && !w_push)
                r_cnt <= r_cnt - CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_starve <= '0;
        else if (w_pop || w_empty)
            r_starve <= '0;
        else if (w_wb_act && r_starve != SMAX)
            r_starve <= r_starve + 4'd1;
    end

    // Selection is combinational: the regfile writes on the falling edge.
    always_comb begin
        wwreg = 1'b0;
        wrn   = '0;
        wdi   = '0;
        if (!reset) begin
            if (w_wb_act) begin
                wwreg = 1'b1;
                wrn   = wb_rn;
                wdi   = wb_di;
            end else if (!w_empty) begin
                wwreg = 1'b1;
                wrn   = r_rn[r_head];
                wdi   = r_di[r_head];
            end
        end
    end

    always_comb begin
        w_pend_a = 1'b0;
        w_pend_b = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && r_rn[i] == rs) w_pend_a = 1'b1;
            if (r_vld[i] && r_rn[i] == rt) w_pend_b = 1'b1;
        end
    end

    assign pend_a    = ~reset & (rs != '0) & w_pend_a;
    assign pend_b    = ~reset & (rt != '0) & w_pend_b;
    assign stall_req = ~reset & (r_starve == SMAX);
    assign fifo_cnt  = r_cnt;

endmodule

// File: tb/tb_pipe_wport_arb.sv
// Bench for pipe_wport_arb: directed vector table, reset corners, and random
// traffic checked against a queue-based reference model.
module tb_pipe_wport_arb;
    localparam int DEPTH = 2;
    localparam int SM    = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock;
    logic          reset;
    logic          wb_wreg;
    logic [4:0]    wb_rn;
    logic [31:0]   wb_di;
    logic          md_valid;
    logic [4:0]    md_rn;
    logic [31:0]   md_di;
    logic          md_ready;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic          wwreg;
    logic [4:0]    wrn;
    logic [31:0]   wdi;
    logic          pend_a;
    logic          pend_b;
    logic          stall_req;
    logic [CW-1:0] fifo_cnt;

    int checks = 0;
    int errors = 0;

    pipe_wport_arb #(.DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clock(clock), .reset(reset),
        .wb_wreg(wb_wreg), .wb_rn(wb_rn), .wb_di(wb_di),
        .md_valid(md_valid), .md_rn(md_rn), .md_di(md_di), .md_ready(md_ready),
        .rs(rs), .rt(rt),
        .wwreg(wwreg), .wrn(wrn), .wdi(wdi),
        .pend_a(pend_a), .pend_b(pend_b), .stall_req(stall_req), .fifo_cnt(fifo_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic wbw; logic [4:0] wbrn; logic [31:0] wbdi;
        logic mdv; logic [4:0] mdrn; logic [31:0] mddi;
        logic [4:0] rs; logic [4:0] rt;
        logic e_ww; logic [4:0] e_wrn; logic [31:0] e_wdi;
        logic e_rdy; logic e_pa; logic e_pb; logic e_st; int e_cnt;
    } vec_t;

    typedef struct { logic [4:0] rn; logic [31:0] di; } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    int   starve = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic a, input logic [4:0] b, input logic [31:0] c,
                         input logic d, input logic [4:0] e, input logic [31:0] f,
                         input logic [4:0] g, input logic [4:0] h);
        wb_wreg = a; wb_rn = b; wb_di = c; md_valid = d; md_rn = e; md_di = f; rs = g; rt = h;
    endtask

    // Reference: FIFO is a queue, WB always wins, starvation is a saturating count.
    task automatic model_edge();
        bit act  = wb_wreg && (wb_rn != 0);
        bit pop  = !act && (mq.size() > 0);
        bit push = md_valid && (mq.size() < DEPTH) && (md_rn != 0);
        if (mq.size() == 0 || pop) starve = 0;
        else if (starve < SM) starve++;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{md_rn, md_di});
    endtask

    task automatic step();
        @(posedge clock);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic check_model();
        bit act = wb_wreg && (wb_rn != 0);
        logic e_ww; logic [4:0] e_wrn; logic [31:0] e_wdi;
        bit pa = 0, pb = 0;
        e_ww = act || (mq.size() > 0);
        e_wrn = act ? wb_rn : (mq.size() > 0 ? mq[0].rn : 5'd0);
        e_wdi = act ? wb_di : (mq.size() > 0 ? mq[0].di : 32'd0);
        foreach (mq[k]) begin
            if (rs != 0 && mq[k].rn == rs) pa = 1;
            if (rt != 0 && mq[k].rn == rt) pb = 1;
        end
        chk("rnd_wwreg", 32'(wwreg), 32'(e_ww));
        chk("rnd_wrn", 32'(wrn), 32'(e_wrn));
        chk("rnd_wdi", wdi, e_wdi);
        chk("rnd_ready", 32'(md_ready), 32'(mq.size() < DEPTH));
        chk("rnd_pend_a", 32'(pend_a), 32'(pa));
        chk("rnd_pend_b", 32'(pend_b), 32'(pb));
        chk("rnd_stall", 32'(stall_req), 32'(starve == SM));
        chk("rnd_cnt", 32'(fifo_cnt), 32'(mq.size()));
    endtask

    initial begin
        // wbw rn di | mdv rn di | rs rt | ww wrn wdi rdy pa pb st cnt
        tbl.push_back('{1, 5, 32'h11, 0, 0, 0,       0, 0, 1, 5, 32'h11, 1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0,      1, 8, 32'hABCD, 8, 0, 0, 0, 0,      1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0,      0, 0, 0,       8, 0, 1, 8, 32'hABCD, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0,      0, 0, 0,       8, 0, 0, 0, 0,      1, 0, 0, 0, 0});
        tbl.push_back('{1, 10, 32'h100, 1, 3, 32'h33, 3, 4, 1, 10, 32'h100, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 11, 32'h101, 1, 4, 32'h44, 3, 4, 1, 11, 32'h101, 1, 1, 0, 0, 1});
        tbl.push_back('{1, 12, 32'h102, 1, 5, 32'h55, 3, 4, 1, 12, 32'h102, 0, 1, 1, 0, 2});
        tbl.push_back('{1, 13, 32'h103, 1, 5, 32'h55, 3, 4, 1, 13, 32'h103, 0, 1, 1, 0, 2});
        tbl.push_back('{1, 14, 32'h104, 1, 5, 32'h55, 3, 4, 1, 14, 32'h104, 0, 1, 1, 0, 2});
        tbl.push_back('{1, 15, 32'h105, 1, 5, 32'h55, 3, 4, 1, 15, 32'h105, 0, 1, 1, 1, 2});
        tbl.push_back('{0, 0, 0,      1, 5, 32'h55,  3, 4, 1, 3, 32'h33,  0, 1, 1, 1, 2});
        tbl.push_back('{0, 0, 0,      1, 5, 32'h55,  3, 4, 1, 4, 32'h44,  1, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 0,      0, 0, 0,       5, 0, 1, 5, 32'h55,  1, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0,      0, 0, 0,       0, 0, 0, 0, 0,      1, 0, 0, 0, 0});
        tbl.push_back('{1, 20, 32'h200, 1, 1, 32'h1, 1, 3, 1, 20, 32'h200, 1, 0, 0, 0, 0});
        tbl.push_back('{1, 21, 32'h201, 1, 2, 32'h2, 1, 3, 1, 21, 32'h201, 1, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 0,      1, 3, 32'h3,   1, 3, 1, 1, 32'h1,   0, 1, 0, 0, 2});
        tbl.push_back('{0, 0, 0,      1, 3, 32'h3,   1, 3, 1, 2, 32'h2,   1, 0, 0, 0, 1});
        tbl.push_back('{0, 0, 0,      0, 0, 0,       1, 3, 1, 3, 32'h3,   1, 0, 1, 0, 1});
        tbl.push_back('{0, 0, 0,      0, 0, 0,       1, 3, 0, 0, 0,      1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0,      1, 0, 32'hDEAD, 0, 0, 0, 0, 0,     1, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 0,      0, 0, 0,       0, 0, 0, 0, 0,      1, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 32'h55, 0, 0, 0,       0, 0, 0, 0, 0,      1, 0, 0, 0, 0});

        // Reset held with traffic offered: outputs forced quiet.
        reset = 1'b1;
        drive(1, 5, 32'h11, 1, 9, 32'h99, 9, 9);
        #2;
        chk("rst_wwreg", 32'(wwreg), 32'd0);
        chk("rst_ready", 32'(md_ready), 32'd0);
        chk("rst_cnt", 32'(fifo_cnt), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].wbw, tbl[i].wbrn, tbl[i].wbdi, tbl[i].mdv, tbl[i].mdrn, tbl[i].mddi,
                  tbl[i].rs, tbl[i].rt);
            @(negedge clock);
            chk($sformatf("v%0d_wwreg", i), 32'(wwreg), 32'(tbl[i].e_ww));
            chk($sformatf("v%0d_wrn", i), 32'(wrn), 32'(tbl[i].e_wrn));
            chk($sformatf("v%0d_wdi", i), wdi, tbl[i].e_wdi);
            chk($sformatf("v%0d_ready", i), 32'(md_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_pend_a", i), 32'(pend_a), 32'(tbl[i].e_pa));
            chk($sformatf("v%0d_pend_b", i), 32'(pend_b), 32'(tbl[i].e_pb));
            chk($sformatf("v%0d_stall", i), 32'(stall_req), 32'(tbl[i].e_st));
            chk($sformatf("v%0d_cnt", i), 32'(fifo_cnt), 32'(tbl[i].e_cnt));
            step();
        end

        // Queue two entries behind WB, then reset asynchronously mid-cycle.
        drive(1, 17, 32'h17, 1, 6, 32'h66, 6, 7);
        step();
        drive(1, 18, 32'h18, 1, 7, 32'h77, 6, 7);
        step();
        drive(0, 0, 0, 0, 0, 0, 6, 7);
        #2;
        chk("pre_arst_cnt", 32'(fifo_cnt), 32'd2);
        chk("pre_arst_pend_a", 32'(pend_a), 32'd1);
        reset = 1'b1;
        #1;
        chk("arst_cnt", 32'(fifo_cnt), 32'd0);
        chk("arst_pend_a", 32'(pend_a), 32'd0);
        chk("arst_pend_b", 32'(pend_b), 32'd0);
        chk("arst_wwreg", 32'(wwreg), 32'd0);
        mq.delete();
        starve = 0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_arst_wwreg", 32'(wwreg), 32'd0);
            chk("post_arst_cnt", 32'(fifo_cnt), 32'd0);
            step();
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            @(negedge clock);
            check_model();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
